// File: rtl/uart_prog_loader.sv
// UART program loader: receives a framed, checksummed image over 8N1 serial and
// writes it word by word into memory, holding the core in reset until it is complete.
module uart_prog_loader #(
   parameter int          CLK_FREQ  = 50_000_000,
   parameter int          BAUD      = 115200,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        uart_rxd,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_rstn,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] MAX_N        = 16'(MAX_WORDS);
   localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LEN0 = 3'd1;
   localparam logic [2:0] ST_LEN1 = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;
   localparam logic [2:0] ST_ERR  = 3'd6;

   logic        rx_s1, rx_s2, rx_s3;
   logic [1:0]  rx_state;
   logic [15:0] clk_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  rx_byte;
   logic        byte_valid;
   logic        frame_err;

   logic [2:0]  state;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic [7:0]  sum;
   logic [15:0] len_new;

   // rx_s3 is the previous synchronised level, used only for falling-edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_s3      <= 1'b1;
         rx_state   <= RX_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_s1      <= uart_rxd;
         rx_s2      <= rx_s1;
         rx_s3      <= rx_s2;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_s3 && !rx_s2) begin
                  clk_cnt  <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  rx_byte <= {rx_s2, rx_byte[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt    <= '0;
                  byte_valid <= rx_s2;
                  frame_err  <= !rx_s2;
                  rx_state   <= RX_IDLE;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   assign len_new = {rx_byte, len[7:0]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         len       <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         word_buf  <= '0;
         sum       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= BASE_ADDR;
         wr_data   <= '0;
         core_rstn <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (byte_valid || frame_err) begin
            case (state)
               ST_IDLE, ST_ERR: begin
                  if (byte_valid && rx_byte == SYNC_BYTE) begin
                     word_idx <= '0;
                     byte_cnt <= '0;
                     sum      <= '0;
                     state    <= ST_LEN0;
                  end
               end
               ST_LEN0: begin
                  if (frame_err) state <= ST_ERR;
                  else begin
                     len[7:0] <= rx_byte;
                     state    <= ST_LEN1;
                  end
               end
               ST_LEN1: begin
                  if (frame_err || len_new > MAX_N) state <= ST_ERR;
                  else begin
                     len   <= len_new;
                     state <= (len_new == 16'd0) ? ST_CSUM : ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (frame_err) state <= ST_ERR;
                  else begin
                     sum      <= sum + rx_byte;
                     byte_cnt <= byte_cnt + 2'd1;
                     case (byte_cnt)
                        2'd0: word_buf[7:0]   <= rx_byte;
                        2'd1: word_buf[15:8]  <= rx_byte;
                        2'd2: word_buf[23:16] <= rx_byte;
                        default: begin
                           wr_en    <= 1'b1;
                           wr_data  <= {rx_byte, word_buf};
                           wr_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                           word_idx <= word_idx + 16'd1;
                           if (word_idx == len - 16'd1) state <= ST_CSUM;
                        end
                     endcase
                  end
               end
               ST_CSUM: begin
                  if (frame_err || rx_byte != sum) state <= ST_ERR;
                  else begin
                     state     <= ST_DONE;
                     core_rstn <= 1'b1;
                  end
               end
               ST_DONE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy = (state == ST_LEN0) || (state == ST_LEN1) ||
                 (state == ST_DATA) || (state == ST_CSUM);
   assign done = (state == ST_DONE);
   assign err  = (state == ST_ERR);

endmodule
